alu_ctrl_muldiv: RTL and testbench

Next-generation ALU control for the MIPS core, with a configurable datapath width. It keeps the combinational aluop/funct to aluControl decode. It adds an iterative multiply/divide unit that owns the HI/LO registers and serves mfhi/mflo/mthi/mtlo. The block sits in EX beside the ALU. It drives a stall request back to the hazard unit while a mult/div is in flight.

---
 rtl/alu_ctrl_muldiv_pkg.sv | 76 +++++++
 rtl/alu_ctrl_muldiv_if.sv | 35 +++
 rtl/alu_ctrl_muldiv_core.sv | 178 +++++++++++++++++
 rtl/alu_ctrl_muldiv.sv | 110 +++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_muldiv_pkg
//  Purpose  : Shared constants and types for the ALU control / mul-div block:
//             ALU command codes, main-decoder aluop codes, R-type funct codes,
//             mul/div FSM state encoding and small funct classifiers.
//  Config   : ALU_DIV_EN - when defined, div/divu are recognised functs.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_ctrl_muldiv_pkg;

    // ALU command codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main-decoder ALU op codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_ADDU  = 6'd33;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_SUBU  = 6'd35;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_NOR   = 6'd39;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;
    localparam logic [5:0] FUNCT_SLTU  = 6'd43;

    // Mul/div sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Operation descriptor handed to the iterative core
    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_op_t;

    // Functs that launch an iterative operation in this build
    function automatic logic funct_is_muldiv(input logic [5:0] f);
        logic r;
        r = (f == FUNCT_MULT) || (f == FUNCT_MULTU);
`ifdef ALU_DIV_EN
        r = r || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
`endif
        return r;
    endfunction

    // Functs that move data to/from HI/LO
    function automatic logic funct_is_hilo(input logic [5:0] f);
        return (f == FUNCT_MFHI) || (f == FUNCT_MTHI) ||
               (f == FUNCT_MFLO) || (f == FUNCT_MTLO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_muldiv_if
//  Purpose  : EX-stage bundle between the pipeline and alu_ctrl_muldiv.
//  Ports    : master drives valid/aluop/funct/rs_val/rt_val and observes
//             alu_control/hilo_rdata/busy/stall/done/illegal; slave is the
//             mirror image used by the design.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_ctrl_muldiv_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [1:0]      aluop;
    logic [5:0]      funct;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] hilo_rdata;
    logic            busy;
    logic            stall;
    logic            done;
    logic            illegal;

    modport master (
        output valid, aluop, funct, rs_val, rt_val,
        input  alu_control, hilo_rdata, busy, stall, done, illegal
    );

    modport slave (
        input  valid, aluop, funct, rs_val, rt_val,
        output alu_control, hilo_rdata, busy, stall, done, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_core
//  Purpose  : Iterative multiply/divide unit owning the HI/LO registers.
//             Shift-add multiply and restoring divide over XLEN iterations,
//             followed by a sign-fix cycle that writes HI/LO.
//  Ports    : clk, rst_n (sync, active low); start_i/op_i/a_i/b_i launch an
//             op; wr_hi_i/wr_lo_i/wdata_i are mthi/mtlo writes (idle only);
//             busy_o/done_o status; hi_o/lo_o current HI/LO.
//  Config   : ALU_DIV_EN - builds the divider path; otherwise only multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_core
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            start_i,
    input  wire md_op_t          op_i,
    input  wire logic [XLEN-1:0] a_i,
    input  wire logic [XLEN-1:0] b_i,
    input  wire logic            wr_hi_i,
    input  wire logic            wr_lo_i,
    input  wire logic [XLEN-1:0] wdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      hi_o,
    output logic [XLEN-1:0]      lo_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    // {acc_q, wrk_q} is the double-width working register: product for
    // multiply, {partial remainder, dividend/quotient} for divide.
    logic [XLEN-1:0]  acc_q;
    logic [XLEN-1:0]  wrk_q;
    logic [XLEN-1:0]  opnd_q;     // multiplicand or divisor magnitude
    logic             neg_lo_q;   // negate product / quotient at fix
    logic             neg_hi_q;   // negate remainder at fix
    logic             is_mul_q;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN:0]    w_mul_sum;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_fix;

    always_comb begin
        w_a_neg    = op_i.is_signed & a_i[XLEN-1];
        w_b_neg    = op_i.is_signed & b_i[XLEN-1];
        w_a_mag    = w_a_neg ? -a_i : a_i;
        w_b_mag    = w_b_neg ? -b_i : b_i;
        // Carry out of the add is kept and shifted back into the top bit.
        w_mul_sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        w_prod     = {acc_q, wrk_q};
        w_prod_fix = neg_lo_q ? -w_prod : w_prod;
    end

`ifdef ALU_DIV_EN
    logic [XLEN:0]   w_div_sh;
    logic [XLEN+1:0] w_div_diff;
    logic            w_div_take;

    always_comb begin
        w_div_sh   = {acc_q, wrk_q[XLEN-1]};
        w_div_diff = {1'b0, w_div_sh} - {2'b00, opnd_q};
        // No borrow means the shifted remainder covers the divisor.
        w_div_take = ~w_div_diff[XLEN+1];
    end
`else
    logic w_unused_div;
    assign w_unused_div = op_i.is_div;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_mul_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        cnt_q  <= CNT_LAST;
`ifdef ALU_DIV_EN
                        if (op_i.is_div) begin
                            is_mul_q <= 1'b0;
                            if (b_i == '0) begin
                                // Divide by zero skips iteration entirely.
                                acc_q    <= a_i;
                                wrk_q    <= '1;
                                neg_lo_q <= 1'b0;
                                neg_hi_q <= 1'b0;
                                state_q  <= ST_FIX;
                            end else begin
                                acc_q    <= '0;
                                wrk_q    <= w_a_mag;
                                opnd_q   <= w_b_mag;
                                neg_lo_q <= w_a_neg ^ w_b_neg;
                                neg_hi_q <= w_a_neg;
                                state_q  <= ST_DIV;
                            end
                        end else
`endif
                        begin
                            acc_q    <= '0;
                            wrk_q    <= w_b_mag;
                            opnd_q   <= w_a_mag;
                            neg_lo_q <= w_a_neg ^ w_b_neg;
                            neg_hi_q <= 1'b0;
                            is_mul_q <= 1'b1;
                            state_q  <= ST_MUL;
                        end
                    end else begin
                        if (wr_hi_i) hi_q <= wdata_i;
                        if (wr_lo_i) lo_q <= wdata_i;
                    end
                end
                ST_MUL: begin
                    acc_q <= w_mul_sum[XLEN:1];
                    wrk_q <= {w_mul_sum[0], wrk_q[XLEN-1:1]};
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
`ifdef ALU_DIV_EN
                ST_DIV: begin
                    acc_q <= w_div_take ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
                    wrk_q <= {wrk_q[XLEN-2:0], w_div_take};
                    if (cnt_q == '0) state_q <= ST_FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
`endif
                ST_FIX: begin
                    if (is_mul_q) begin
                        {hi_q, lo_q} <= w_prod_fix;
                    end else begin
                        hi_q <= neg_hi_q ? -acc_q : acc_q;
                        lo_q <= neg_lo_q ? -wrk_q : wrk_q;
                    end
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_muldiv
//  Purpose  : EX-stage ALU control decode plus HI/LO mult/div front end.
//             Decodes aluop/funct into the ALU command, flags unknown R-type
//             functs, stalls HI/LO and mul/div requests while the iterative
//             unit is busy, and muxes HI/LO for mfhi/mflo.
//  Ports    : clk, rst_n (sync, active low); bus (alu_ctrl_muldiv_if.slave):
//             valid/aluop/funct/rs_val/rt_val in, alu_control/hilo_rdata/
//             busy/stall/done/illegal out.
//  Config   : ALU_DIV_EN - enables div/divu; otherwise they decode illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_muldiv
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_ctrl_muldiv_if.slave  bus
);

    logic [3:0]      w_alu_ctrl;
    logic            w_known;
    logic            w_rtype;
    logic            w_busy;
    logic            w_done;
    logic            w_start;
    md_op_t          w_op;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_hilo;

    always_comb begin
        w_alu_ctrl = ALU_AND;
        w_known    = 1'b1;
        case (bus.aluop)
            ALUOP_ADD: w_alu_ctrl = ALU_ADD;
            ALUOP_SUB: w_alu_ctrl = ALU_SUB;
            ALUOP_ORI: w_alu_ctrl = ALU_OR;
            default: begin
                case (bus.funct)
                    FUNCT_ADD,  FUNCT_ADDU: w_alu_ctrl = ALU_ADD;
                    FUNCT_SUB,  FUNCT_SUBU: w_alu_ctrl = ALU_SUB;
                    FUNCT_AND:              w_alu_ctrl = ALU_AND;
                    FUNCT_OR:               w_alu_ctrl = ALU_OR;
                    FUNCT_NOR:              w_alu_ctrl = ALU_NOR;
                    FUNCT_SLT,  FUNCT_SLTU: w_alu_ctrl = ALU_SLT;
                    // HI/LO ops pass through the ALU as a harmless add.
                    FUNCT_MFHI, FUNCT_MTHI,
                    FUNCT_MFLO, FUNCT_MTLO,
                    FUNCT_MULT, FUNCT_MULTU: w_alu_ctrl = ALU_ADD;
`ifdef ALU_DIV_EN
                    FUNCT_DIV,  FUNCT_DIVU: w_alu_ctrl = ALU_ADD;
`endif
                    default: begin
                        w_alu_ctrl = ALU_AND;
                        w_known    = 1'b0;
                    end
                endcase
            end
        endcase
    end

    assign w_rtype = bus.valid && (bus.aluop == ALUOP_RTYPE);
    assign w_start = w_rtype && !w_busy && funct_is_muldiv(bus.funct);

    assign w_op.is_div    = (bus.funct == FUNCT_DIV) || (bus.funct == FUNCT_DIVU);
    assign w_op.is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);

    muldiv_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (w_start),
        .op_i    (w_op),
        .a_i     (bus.rs_val),
        .b_i     (bus.rt_val),
        .wr_hi_i (w_rtype && !w_busy && (bus.funct == FUNCT_MTHI)),
        .wr_lo_i (w_rtype && !w_busy && (bus.funct == FUNCT_MTLO)),
        .wdata_i (bus.rs_val),
        .busy_o  (w_busy),
        .done_o  (w_done),
        .hi_o    (w_hi),
        .lo_o    (w_lo)
    );

    // mfhi/mflo read only when the unit is idle; a stalled read returns 0.
    always_comb begin
        w_hilo = '0;
        if (w_rtype && !w_busy) begin
            if (bus.funct == FUNCT_MFHI)      w_hilo = w_hi;
            else if (bus.funct == FUNCT_MFLO) w_hilo = w_lo;
        end
    end

    assign bus.alu_control = w_alu_ctrl;
    assign bus.hilo_rdata  = w_hilo;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.illegal     = w_rtype && !w_known;
    assign bus.stall       = w_rtype && w_busy &&
                             (funct_is_muldiv(bus.funct) || funct_is_hilo(bus.funct));

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_muldiv
//  Purpose  : Directed bench for alu_ctrl_muldiv (XLEN=32) with an
//             arithmetic reference model checked every cycle.
//  Config   : ALU_DIV_EN - selects the divide scenarios or the illegal-div
//             scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_muldiv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_muldiv_if #(.XLEN(32)) bus();

    alu_ctrl_muldiv #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    int          sa, sb;
    longint      sp;
    logic [63:0] up;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else if (bus.valid && bus.aluop == 2'b10) begin
                sa = $signed(bus.rs_val);
                sb = $signed(bus.rt_val);
                case (bus.funct)
                    6'd17: m_hi = bus.rs_val;
                    6'd19: m_lo = bus.rs_val;
                    6'd24: begin sp = longint'(sa) * longint'(sb); {p_hi, p_lo} = sp; m_left = 33; end
                    6'd25: begin up = {32'd0, bus.rs_val} * {32'd0, bus.rt_val}; {p_hi, p_lo} = up; m_left = 33; end
`ifdef ALU_DIV_EN
                    6'd26: begin
                        if (sb == 0) begin p_lo = '1; p_hi = bus.rs_val; m_left = 1; end
                        else begin p_lo = sa / sb; p_hi = sa % sb; m_left = 33; end
                    end
                    6'd27: begin
                        if (sb == 0) begin p_lo = '1; p_hi = bus.rs_val; m_left = 1; end
                        else begin p_lo = bus.rs_val / bus.rt_val; p_hi = bus.rs_val % bus.rt_val; m_left = 33; end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    function automatic bit f_known(input logic [5:0] f);
        case (f)
            6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25,
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd39, 6'd42, 6'd43: return 1'b1;
`ifdef ALU_DIV_EN
            6'd26, 6'd27: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'd32, 6'd33: return 4'b0010;
            6'd34, 6'd35: return 4'b0110;
            6'd37:        return 4'b0001;
            6'd39:        return 4'b1100;
            6'd42, 6'd43: return 4'b0111;
            default:      return (f_known(f) && f != 6'd36) ? 4'b0010 : 4'b0000;
        endcase
    endfunction

    function automatic bit f_hazard(input logic [5:0] f);
        return (f >= 6'd16 && f <= 6'd19) || f == 6'd24 || f == 6'd25
`ifdef ALU_DIV_EN
               || f == 6'd26 || f == 6'd27
`endif
               ;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    bus.busy, 64'(m_left > 0));
            check("done",    bus.done, 64'(m_done));
            check("stall",   bus.stall,
                  64'(bus.valid && bus.aluop == 2'b10 && m_left > 0 && f_hazard(bus.funct)));
            check("illegal", bus.illegal,
                  64'(bus.valid && bus.aluop == 2'b10 && !f_known(bus.funct)));
            check("alu_control", bus.alu_control, 64'(f_ctl(bus.aluop, bus.funct)));
            if (bus.valid && bus.aluop == 2'b10 && m_left == 0 && bus.funct == 6'd16)
                check("hilo_rdata", bus.hilo_rdata, 64'(m_hi));
            else if (bus.valid && bus.aluop == 2'b10 && m_left == 0 && bus.funct == 6'd18)
                check("hilo_rdata", bus.hilo_rdata, 64'(m_lo));
            else
                check("hilo_rdata", bus.hilo_rdata, 64'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
        bus.valid = v; bus.aluop = op; bus.funct = f; bus.rs_val = a; bus.rt_val = b;
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check("busy_timeout", 64'(n), 64'd33);
    endtask

    int n;
    int dones;

    initial begin
        put(0, 2'b00, 6'd0, 0, 0);
        rst_n = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        rst_n = 1'b1;
        tick(1);
        put(1, 2'b10, 6'd16, 0, 0);
        check("reset_hi", bus.hilo_rdata, 0);

        // decode
        put(1, 2'b00, 6'd36, 0, 0); check("dec_add", bus.alu_control, 4'b0010);
        tick(1);
        put(1, 2'b01, 6'd0, 0, 0);  check("dec_sub", bus.alu_control, 4'b0110);
        tick(1);
        put(1, 2'b10, 6'd36, 0, 0); check("dec_and", bus.alu_control, 4'b0000);
        tick(1);
        put(1, 2'b10, 6'd42, 0, 0); check("dec_slt", bus.alu_control, 4'b0111);
        check("dec_slt_legal", bus.illegal, 0);
        tick(1);
        put(1, 2'b10, 6'd63, 0, 0); check("dec_illegal", bus.illegal, 1);
        tick(1);
        put(0, 2'b10, 6'd63, 0, 0); check("illegal_novalid", bus.illegal, 0);
        tick(1);
        put(1, 2'b10, 6'd39, 0, 0); tick(1);
        put(1, 2'b11, 6'd0, 0, 0);  tick(1);

        // mthi / mtlo
        put(1, 2'b10, 6'd17, 32'h1234, 0); tick(1);
        put(1, 2'b10, 6'd16, 0, 0); check("mfhi_1234", bus.hilo_rdata, 32'h1234);
        tick(1);
        put(1, 2'b10, 6'd19, 32'h5678, 0); tick(1);
        put(1, 2'b10, 6'd18, 0, 0); check("mflo_5678", bus.hilo_rdata, 32'h5678);
        tick(1);

        // mult 7 * -3
        put(1, 2'b10, 6'd24, 32'd7, 32'hFFFFFFFD); tick(1);
        put(0, 2'b00, 6'd0, 0, 0);
        wait_idle(n);
        check("mult_busy_len", 64'(n), 33);
        check("mult_done", bus.done, 1);
        put(1, 2'b10, 6'd16, 0, 0); check("mult_hi", bus.hilo_rdata, 32'hFFFFFFFF);
        tick(1);
        put(1, 2'b10, 6'd18, 0, 0); check("mult_lo", bus.hilo_rdata, 32'hFFFFFFEB);
        tick(1);

        // multu with hazards: add during busy, mflo stalled until idle
        put(1, 2'b10, 6'd25, 32'hFFFFFFFF, 32'd2); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); tick(2);
        put(1, 2'b10, 6'd32, 1, 2);
        check("add_nostall", bus.stall, 0);
        check("add_ctl", bus.alu_control, 4'b0010);
        tick(2);
        put(1, 2'b10, 6'd18, 0, 0);
        check("mflo_stall", bus.stall, 1);
        wait_idle(n);
        check("mflo_unstall", bus.stall, 0);
        check("multu_lo", bus.hilo_rdata, 32'hFFFFFFFE);
        tick(1);
        put(1, 2'b10, 6'd16, 0, 0); check("multu_hi", bus.hilo_rdata, 32'h1);
        tick(1);

        // signed mult, both negative (model-checked)
        put(1, 2'b10, 6'd24, 32'hFFFFFFFB, 32'hFFFFFFFC); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); wait_idle(n);
        put(1, 2'b10, 6'd18, 0, 0); check("mult_neg_lo", bus.hilo_rdata, 32'd20);
        tick(1);

        // multu to leave nonzero HI/LO, then reset at iteration 10
        put(1, 2'b10, 6'd25, 32'h10000, 32'h30000); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); tick(10);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_done", bus.done, 0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            tick(1);
        end
        check("rst_no_done", 64'(dones), 0);
        put(1, 2'b10, 6'd16, 0, 0); check("rst_hi", bus.hilo_rdata, 0);
        tick(1);
        put(1, 2'b10, 6'd18, 0, 0); check("rst_lo", bus.hilo_rdata, 0);
        tick(1);

`ifdef ALU_DIV_EN
        put(1, 2'b10, 6'd26, 32'hFFFFFFF9, 32'd2); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); wait_idle(n);
        check("div_busy_len", 64'(n), 33);
        put(1, 2'b10, 6'd18, 0, 0); check("div_lo", bus.hilo_rdata, 32'hFFFFFFFD);
        tick(1);
        put(1, 2'b10, 6'd16, 0, 0); check("div_hi", bus.hilo_rdata, 32'hFFFFFFFF);
        tick(1);
        put(1, 2'b10, 6'd27, 32'd100, 32'd0); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); wait_idle(n);
        check("div0_busy_len", 64'(n), 1);
        check("div0_done", bus.done, 1);
        put(1, 2'b10, 6'd18, 0, 0); check("div0_lo", bus.hilo_rdata, 32'hFFFFFFFF);
        tick(1);
        put(1, 2'b10, 6'd16, 0, 0); check("div0_hi", bus.hilo_rdata, 32'h64);
        tick(1);
        put(1, 2'b10, 6'd26, 32'd7, 32'hFFFFFFFE); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); wait_idle(n);
        put(1, 2'b10, 6'd18, 0, 0); check("div_pn_lo", bus.hilo_rdata, 32'hFFFFFFFD);
        tick(1);
        put(1, 2'b10, 6'd16, 0, 0); check("div_pn_hi", bus.hilo_rdata, 32'd1);
        tick(1);
        put(1, 2'b10, 6'd27, 32'd100, 32'd7); tick(1);
        put(0, 2'b00, 6'd0, 0, 0); wait_idle(n);
        put(1, 2'b10, 6'd18, 0, 0); check("divu_lo", bus.hilo_rdata, 32'd14);
        tick(1);
`else
        put(1, 2'b10, 6'd17, 32'hAAAA, 0); tick(1);
        put(1, 2'b10, 6'd19, 32'h5555, 0); tick(1);
        put(1, 2'b10, 6'd26, 32'hFFFFFFF9, 32'd2);
        check("nodiv_illegal", bus.illegal, 1);
        tick(1);
        check("nodiv_busy", bus.busy, 0);
        put(1, 2'b10, 6'd27, 32'd100, 32'd0);
        check("nodivu_illegal", bus.illegal, 1);
        tick(1);
        check("nodivu_busy", bus.busy, 0);
        put(1, 2'b10, 6'd16, 0, 0); check("nodiv_hi", bus.hilo_rdata, 32'hAAAA);
        tick(1);
        put(1, 2'b10, 6'd18, 0, 0); check("nodiv_lo", bus.hilo_rdata, 32'h5555);
        tick(1);
`endif

        put(0, 2'b00, 6'd0, 0, 0);
        tick(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
